gcd_engine_param: RTL and testbench
===================================

Name: gcd_engine_param

Overview:
- Parametrised successor to the fixed 16-bit GCD datapath/controlpath pair.
- Loads both operands in one cycle over a valid/ready handshake.
- Computes GCD with a compile-time choice of subtractive Euclid or binary (Stein) algorithm.
- Holds the result on a valid/ready output port until consumed.
- Sits between an operand producer and a result consumer in the arithmetic subsystem, one clock domain.

Parameters:
- WIDTH, 16: operand and result width in bits, minimum 2.
- MODE, 0: 0 = subtractive Euclid; 1 = binary GCD (Stein).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair is valid.
- in_ready  output  1  engine accepts operands; equals (state==IDLE) && !rst.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- gcd_out  output  WIDTH  GCD result.
- zero_err  output  1  both operands were 0; valid while out_valid is high.
- cycles  output  WIDTH+1  number of CALC cycles used; present only with GCD_CYCLE_COUNT_EN.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high; ports are clk and rst.
- Reset (rst high at an edge): the following are forced, overriding any operation in progress (mid-CALC or DONE); no partial result is ever emitted.
  - state = IDLE
  - out_valid = 0, gcd_out = 0, zero_err = 0, cycles = 0
  - internal A, B, k = 0
- States: IDLE, CALC, DONE.
- IDLE:
  - An accept occurs when in_valid && in_ready at an edge.
  - On accept, A <= a_in, B <= b_in, k <= 0, count <= 0.
  - If a_in==0 or b_in==0, go directly to DONE with gcd_out = a_in|b_in and cycles = 0; out_valid is high the next cycle.
  - If both are 0, gcd_out = 0 and zero_err = 1.
  - Otherwise go to CALC.
- CALC, one step per cycle; count increments every CALC cycle, saturating at all-ones.
  - MODE 0:
    - If A==B: gcd_out <= A, go to DONE.
    - Else if A<B: B <= B-A.
    - Else: A <= A-B.
  - MODE 1, priority order:
    - A==B: gcd_out <= A<<k (truncated to WIDTH), go to DONE.
    - A and B both even: A>>=1, B>>=1, k++.
    - A even: A>>=1.
    - B even: B>>=1.
    - A>B: A <= (A-B)>>1.
    - Otherwise: B <= (B-A)>>1.
  - k is clog2(WIDTH)+1 bits wide.
  - The final equality cycle is counted, and cycles latches count+1 on entry to DONE.
- DONE:
  - out_valid = 1; gcd_out, zero_err and cycles stay stable.
  - On out_valid && out_ready at an edge: out_valid <= 0, go to IDLE.
  - in_ready is 0 throughout CALC and DONE, so in_valid is ignored there.
  - Back-to-back throughput: at least one IDLE cycle between results.
- Arithmetic:
  - Unsigned only.
  - Subtraction is performed only when the minuend is greater than or equal to the subtrahend, so it never wraps.
  - Worst case for MODE 0 is (2^WIDTH-1, 1), which takes 2^WIDTH-1 CALC cycles; the counter width covers this without saturating.
  - MODE 1 completes in at most 2*WIDTH+1 CALC cycles.
- An in_valid/out_ready change in the same cycle as rst has no effect.

Optional Feature:
- Macro GCD_CYCLE_COUNT_EN.
- Defined: the cycles port and the internal count register exist as described above.
- Undefined: the cycles port is absent, no count register is built, and all other behaviour is identical.

Test Plan:
- MODE0, A=143, B=78 accepted at edge E0 -> CALC steps (65,78)(65,13)(52,13)(39,13)(26,13)(13,13) then equal; at E7 out_valid=1, gcd_out=13, cycles=7, zero_err=0.
- MODE1, A=48, B=18 -> steps (24,9,k=1)(12,9)(6,9)(3,9)(3,3) then equal; gcd_out=6, cycles=6. Also MODE1 (143,78) -> gcd_out=13, cycles=6.
- Zero operands: (0,35) -> gcd_out=35, cycles=0, out_valid one cycle after accept. (0,0) -> gcd_out=0, zero_err=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> gcd_out/cycles stable, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 for one cycle -> out_valid drops and in_ready=1 on the next cycle.
- Reset mid-operation: MODE0 (65535,1), assert rst during CALC cycle 100 -> next cycle state IDLE, out_valid=0, gcd_out=0, in_ready=1 after rst falls. A new pair (12,8) then yields 4.
- WIDTH=8, MODE0 (255,1) -> gcd_out=1, cycles=255. The same pair under MODE1 -> gcd_out=1, cycles at most 17.

Source files
------------

// File: rtl/gcd_engine_param.sv
// Parametrised GCD engine: subtractive Euclid (MODE 0) or binary Stein (MODE 1).
// Define GCD_CYCLE_COUNT_EN to build the CALC-cycle counter and the cycles port.
module gcd_engine_param #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned MODE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd_out,
`ifdef GCD_CYCLE_COUNT_EN
   output logic             zero_err,
   output logic [WIDTH:0]   cycles
`else
   output logic             zero_err
`endif
);

   localparam int unsigned KW = $clog2(WIDTH) + 1;
   localparam int unsigned CW = WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] a_minus_b, b_minus_a;

   assign in_ready  = (state_q == StIdle) && !rst;
   assign a_minus_b = a_q - b_q;
   assign b_minus_a = b_q - a_q;

`ifdef GCD_CYCLE_COUNT_EN
   logic [WIDTH:0] count_q;
   logic [WIDTH:0] count_inc;

   // Saturating so a stuck count can never wrap back to a small value.
   assign count_inc = (count_q == '1) ? count_q : count_q + CW'(1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         out_valid <= 1'b0;
         gcd_out   <= '0;
         zero_err  <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         k_q       <= '0;
`ifdef GCD_CYCLE_COUNT_EN
         count_q   <= '0;
         cycles    <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q      <= a_in;
                  b_q      <= b_in;
                  k_q      <= '0;
                  zero_err <= (a_in == '0) && (b_in == '0);
`ifdef GCD_CYCLE_COUNT_EN
                  count_q  <= '0;
`endif
                  if ((a_in == '0) || (b_in == '0)) begin
                     gcd_out   <= a_in | b_in;
                     out_valid <= 1'b1;
                     state_q   <= StDone;
`ifdef GCD_CYCLE_COUNT_EN
                     cycles    <= '0;
`endif
                  end else begin
                     state_q <= StCalc;
                  end
               end
            end

            StCalc: begin
`ifdef GCD_CYCLE_COUNT_EN
               count_q <= count_inc;
`endif
               if (a_q == b_q) begin
                  // k stays 0 in MODE 0, so the shift is a no-op there.
                  gcd_out   <= a_q << k_q;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
`ifdef GCD_CYCLE_COUNT_EN
                  cycles    <= count_inc;
`endif
               end else if (MODE == 0) begin
                  if (a_q < b_q) b_q <= b_minus_a;
                  else           a_q <= a_minus_b;
               end else begin
                  if (!a_q[0] && !b_q[0]) begin
                     a_q <= a_q >> 1;
                     b_q <= b_q >> 1;
                     k_q <= k_q + KW'(1);
                  end else if (!a_q[0]) begin
                     a_q <= a_q >> 1;
                  end else if (!b_q[0]) begin
                     b_q <= b_q >> 1;
                  end else if (a_q > b_q) begin
                     a_q <= a_minus_b >> 1;
                  end else begin
                     b_q <= b_minus_a >> 1;
                  end
               end
            end

            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_engine_param.sv
// Directed bench for gcd_engine_param: four instances (W16/W8 x MODE0/MODE1).
// Cycle-count checks are compiled in only with GCD_CYCLE_COUNT_EN.
module tb_gcd_engine_param;

   logic        clk;
   logic        rst;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [3:0]  out_valid;
   logic [3:0]  zero_err;
   logic        out_ready;
   logic [15:0] a_in, b_in;
   logic [15:0] g0, g1;
   logic [7:0]  g2, g3;
   logic [15:0] gcd_w [4];

   int checks = 0;
   int errors = 0;

   assign gcd_w[0] = g0;
   assign gcd_w[1] = g1;
   assign gcd_w[2] = {8'h00, g2};
   assign gcd_w[3] = {8'h00, g3};

`ifdef GCD_CYCLE_COUNT_EN
   logic [16:0] c0, c1;
   logic [8:0]  c2, c3;
   logic [16:0] cyc_w [4];
   assign cyc_w[0] = c0;
   assign cyc_w[1] = c1;
   assign cyc_w[2] = {8'h00, c2};
   assign cyc_w[3] = {8'h00, c3};
`endif

   gcd_engine_param #(.WIDTH(16), .MODE(0)) u_d0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a_in(a_in), .b_in(b_in), .out_valid(out_valid[0]), .out_ready(out_ready),
`ifdef GCD_CYCLE_COUNT_EN
      .cycles(c0),
`endif
      .gcd_out(g0), .zero_err(zero_err[0]));

   gcd_engine_param #(.WIDTH(16), .MODE(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a_in(a_in), .b_in(b_in), .out_valid(out_valid[1]), .out_ready(out_ready),
`ifdef GCD_CYCLE_COUNT_EN
      .cycles(c1),
`endif
      .gcd_out(g1), .zero_err(zero_err[1]));

   gcd_engine_param #(.WIDTH(8), .MODE(0)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a_in(a_in[7:0]), .b_in(b_in[7:0]), .out_valid(out_valid[2]), .out_ready(out_ready),
`ifdef GCD_CYCLE_COUNT_EN
      .cycles(c2),
`endif
      .gcd_out(g2), .zero_err(zero_err[2]));

   gcd_engine_param #(.WIDTH(8), .MODE(1)) u_d3 (
      .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .a_in(a_in[7:0]), .b_in(b_in[7:0]), .out_valid(out_valid[3]), .out_ready(out_ready),
`ifdef GCD_CYCLE_COUNT_EN
      .cycles(c3),
`endif
      .gcd_out(g3), .zero_err(zero_err[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One transaction on instance idx; hold > 0 adds a backpressure phase with a stray in_valid.
   task automatic run(input int idx, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eg, input logic ez, input int ecyc,
                      input int hold, input string tag);
      int n;
      @(negedge clk);
      a_in = a;
      b_in = b;
      in_valid[idx] = 1'b1;
      check({tag, " in_ready"}, 32'(in_ready[idx]), 32'd1);
      @(negedge clk);
      in_valid[idx] = 1'b0;
      n = 1;
      while (!out_valid[idx] && n < 70000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'(ecyc + 1));
      check({tag, " gcd"}, 32'(gcd_w[idx]), 32'(eg));
      check({tag, " zero_err"}, 32'(zero_err[idx]), 32'(ez));
`ifdef GCD_CYCLE_COUNT_EN
      check({tag, " cycles"}, 32'(cyc_w[idx]), 32'(ecyc));
`endif
      check({tag, " busy"}, 32'(in_ready[idx]), 32'd0);
      for (int i = 0; i < hold; i++) begin
         if (i == 3) begin
            a_in = 16'd1;
            b_in = 16'd1;
            in_valid[idx] = 1'b1;
         end else begin
            in_valid[idx] = 1'b0;
         end
         @(negedge clk);
         check({tag, " hold valid"}, 32'(out_valid[idx]), 32'd1);
         check({tag, " hold gcd"}, 32'(gcd_w[idx]), 32'(eg));
         check({tag, " hold ready"}, 32'(in_ready[idx]), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
         check({tag, " hold cycles"}, 32'(cyc_w[idx]), 32'(ecyc));
`endif
      end
      in_valid[idx] = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " consumed"}, 32'(out_valid[idx]), 32'd0);
      check({tag, " idle"}, 32'(in_ready[idx]), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 4'b0;
      out_ready = 1'b0;
      a_in      = '0;
      b_in      = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("reset out_valid", 32'(out_valid[i]), 32'd0);
         check("reset gcd", 32'(gcd_w[i]), 32'd0);
         check("reset zero_err", 32'(zero_err[i]), 32'd0);
         check("reset in_ready", 32'(in_ready[i]), 32'd0);
      end
      rst = 1'b0;
      #1;
      check("post reset in_ready", 32'(in_ready), 32'hF);

      run(0, 16'd143, 16'd78, 16'd13, 1'b0, 7, 10, "m0 143 78 backpressure");
      run(1, 16'd48, 16'd18, 16'd6, 1'b0, 6, 0, "m1 48 18");
      run(1, 16'd143, 16'd78, 16'd13, 1'b0, 6, 0, "m1 143 78");
      run(0, 16'd0, 16'd35, 16'd35, 1'b0, 0, 0, "m0 0 35");
      run(0, 16'd0, 16'd0, 16'd0, 1'b1, 0, 0, "m0 0 0");
      run(1, 16'd0, 16'd0, 16'd0, 1'b1, 0, 0, "m1 0 0");
      run(0, 16'd35, 16'd0, 16'd35, 1'b0, 0, 0, "m0 35 0");
      run(2, 16'd255, 16'd1, 16'd1, 1'b0, 255, 0, "w8 m0 255 1");
      run(3, 16'd255, 16'd1, 16'd1, 1'b0, 8, 0, "w8 m1 255 1");

      // Reset during the long MODE 0 worst case.
      @(negedge clk);
      a_in = 16'd65535;
      b_in = 16'd1;
      in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (99) @(negedge clk);
      check("mid calc out_valid", 32'(out_valid[0]), 32'd0);
      rst = 1'b1;
      in_valid[0] = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("midrst out_valid", 32'(out_valid[0]), 32'd0);
      check("midrst gcd", 32'(gcd_w[0]), 32'd0);
      check("midrst zero_err", 32'(zero_err[0]), 32'd0);
      check("midrst in_ready", 32'(in_ready[0]), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
      check("midrst cycles", 32'(cyc_w[0]), 32'd0);
`endif
      rst = 1'b0;
      in_valid[0] = 1'b0;
      out_ready = 1'b0;
      #1;
      check("midrst ready after", 32'(in_ready[0]), 32'd1);
      run(0, 16'd12, 16'd8, 16'd4, 1'b0, 3, 0, "m0 12 8 after rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
